deinterleaver_rx: RTL and testbench

- Receive-side block deinterleaver for the WiMAX PHY (QPSK, rate-1/2 path), the inverse of the transmit interleaver.
- Accepts one serial hard-decision bit per handshake from the QPSK demapper.
- Buffers one 192-bit block in a ping-pong store and emits the bits serially in original (pre-interleave) order to the FEC decoder.
- Runs entirely in the 100 MHz domain.

---
 rtl/deinterleaver_rx_pkg.sv | 18 +
 rtl/deinterleaver_rx_rd_addr_gen.sv | 62 ++++++
 rtl/deinterleaver_rx.sv | 85 ++++++++
 tb/tb_deinterleaver_rx.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deinterleaver_rx_pkg.sv
// Shared constants and types for the WiMAX QPSK rate-1/2 receive deinterleaver.
package Package_wimax;

  localparam int unsigned NCBPS  = 192;
  localparam int unsigned NCOL   = 16;
  localparam int unsigned NROW   = NCBPS / NCOL;
  localparam int unsigned ADDR_W = $clog2(NCBPS);
  localparam int unsigned COL_W  = $clog2(NCOL);
  localparam int unsigned ROW_W  = $clog2(NROW);

  typedef enum logic {BANK_FREE, BANK_FULL} bank_state_e;

  // Output position k of the bit that was received at position j.
  function automatic int unsigned deint_index(input int unsigned j);
    return NCOL * (j % NROW) + j / NROW;
  endfunction

endpackage

// File: rtl/deinterleaver_rx_rd_addr_gen.sv
// Read address generator: walks output order k = 16*row + col and produces the
// stored address j = 12*col + row by incremental stepping, no multiplier.
module deint_rd_addr_gen
  import Package_wimax::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last
);

  localparam logic [COL_W-1:0]  ColLast   = COL_W'(NCOL - 1);
  localparam logic [ROW_W-1:0]  RowLast   = ROW_W'(NROW - 1);
  localparam logic [ADDR_W-1:0] ColStride = ADDR_W'(NROW);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign col     = col_q;
  assign row     = row_q;
  assign rd_addr = addr_q;
  assign last    = (col_q == ColLast) && (row_q == RowLast);

  // Next position: step across a row by the column stride, wrap to the next row start.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (step) begin
      if (col_q != ColLast) begin
        col_d  = col_q + 1'b1;
        addr_d = addr_q + ColStride;
      end else if (row_q != RowLast) begin
        col_d  = '0;
        row_d  = row_q + 1'b1;
        addr_d = ADDR_W'(row_q) + 1'b1;
      end else begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/deinterleaver_rx.sv
// Receive block deinterleaver: fills one 192-bit bank serially while the other
// bank drains in original (pre-interleave) order.
module deinterleaver_rx
  import Package_wimax::*;
(
  input  logic clk_100,
  input  logic reset_N,
  input  logic valid_in,
  input  logic data_in,
  output logic ready_out,
  output logic valid_out,
  output logic data_out,
  output logic sob_out,
  input  logic ready_in
);

  localparam logic [ADDR_W-1:0] WrLast = ADDR_W'(NCBPS - 1);

  logic              init_q;
  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [NCBPS-1:0]  mem_q [2];

  logic              accept;
  logic              wr_last;
  logic              xfer;
  logic              rd_last;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rd_addr;

  // init_q keeps ready_out low until the first clock edge after reset release.
  assign ready_out = init_q & (bank_q[wr_bank_q] == BANK_FREE);
  assign valid_out = (bank_q[rd_bank_q] == BANK_FULL);
  assign data_out  = valid_out & mem_q[rd_bank_q][rd_addr];
  assign sob_out   = valid_out & (col == '0) & (row == '0);

  assign accept  = valid_in & ready_out;
  assign wr_last = accept & (wr_cnt_q == WrLast);
  assign xfer    = valid_out & ready_in;

  deint_rd_addr_gen u_rd_addr_gen (
    .clk     (clk_100),
    .rst_n   (reset_N),
    .step    (xfer),
    .col     (col),
    .row     (row),
    .rd_addr (rd_addr),
    .last    (rd_last)
  );

  // Bank flags: writer sets a free bank, reader clears a full one; never the same bank.
  always_comb begin
    bank_d = bank_q;
    if (wr_last) bank_d[wr_bank_q] = BANK_FULL;
    if (xfer && rd_last) bank_d[rd_bank_q] = BANK_FREE;
  end

  // Control state: bank flags, bank pointers and write counter.
  always_ff @(posedge clk_100 or negedge reset_N) begin
    if (!reset_N) begin
      init_q    <= 1'b0;
      bank_q[0] <= BANK_FREE;
      bank_q[1] <= BANK_FREE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      init_q <= 1'b1;
      bank_q <= bank_d;
      if (accept) wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
      if (wr_last) wr_bank_q <= ~wr_bank_q;
      if (xfer && rd_last) rd_bank_q <= ~rd_bank_q;
    end
  end

  // Bit storage, deliberately not reset.
  always_ff @(posedge clk_100) begin
    if (accept) mem_q[wr_bank_q][wr_cnt_q] <= data_in;
  end

endmodule

// File: tb/tb_deinterleaver_rx.sv
// Self-checking bench for deinterleaver_rx with a TX-interleaver reference model.
module tb_deinterleaver_rx;
  import Package_wimax::*;

  logic clk_100 = 1'b0;
  logic reset_N = 1'b0;
  logic valid_in = 1'b0;
  logic data_in = 1'b0;
  logic ready_in = 1'b0;
  logic ready_out, valid_out, data_out, sob_out;

  int checks = 0;
  int failures = 0;

  // orig: bits in original order; txb: same bits after the transmit interleaver.
  bit orig [3][192];
  bit txb  [3][192];

  deinterleaver_rx dut (
    .clk_100   (clk_100),
    .reset_N   (reset_N),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sob_out   (sob_out),
    .ready_in  (ready_in)
  );

  always #5 clk_100 = ~clk_100;

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmit interleaver: original bit k goes to channel position 12*(k mod 16) + floor(k/16).
  task automatic make_block(input int b);
    for (int k = 0; k < 192; k++) orig[b][k] = 1'($urandom);
    for (int k = 0; k < 192; k++) txb[b][12 * (k % 16) + k / 16] = orig[b][k];
  endtask

  // Push one interleaved block with the reader stalled.
  task automatic feed_block(input int b);
    int j = 0;
    int guard = 0;
    ready_in = 1'b0;
    while (j < 192 && guard < 1000) begin
      @(negedge clk_100);
      valid_in = 1'b1;
      data_in  = txb[b][j];
      if (ready_out) j++;
      guard++;
    end
    checks++;
    if (j != 192) begin
      failures++;
      $display("FAIL feed_block accepted=%0d expected=192", j);
    end
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    #1;
    checks++;
    if ({ready_out, valid_out, data_out, sob_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0000", {ready_out, valid_out, data_out, sob_out});
    end
    repeat (3) @(negedge clk_100);
    checks++;
    if (ready_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_ready got=%b expected=0", ready_out);
    end
    reset_N = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      failures++;
      $display("FAIL release_before_edge_ready got=%b expected=0", ready_out);
    end
    @(negedge clk_100);
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL release_after_edge ready=%b valid=%b expected ready=1 valid=0",
               ready_out, valid_out);
    end
  endtask

  task automatic test_impulse();
    int jimp [5] = '{12, 1, 0, 191, 11};
    int kexp [5] = '{1, 16, 0, 191, 176};
    for (int t = 0; t < 5; t++) begin
      int ones = 0;
      int pos = -1;
      int missing = 0;
      for (int j = 0; j < 192; j++) txb[0][j] = (j == jimp[t]);
      feed_block(0);
      @(negedge clk_100);
      valid_in = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || sob_out !== 1'b1) begin
        failures++;
        $display("FAIL impulse_latency j=%0d valid=%b sob=%b expected 1 1",
                 jimp[t], valid_out, sob_out);
      end
      for (int k = 0; k < 192; k++) begin
        ready_in = 1'b1;
        if (!valid_out) missing++;
        if (data_out) begin
          ones++;
          pos = k;
        end
        @(negedge clk_100);
      end
      ready_in = 1'b0;
      checks++;
      if (ones != 1 || pos != kexp[t] || missing != 0) begin
        failures++;
        $display("FAIL impulse j=%0d ones=%0d pos=%0d missing=%0d expected ones=1 pos=%0d",
                 jimp[t], ones, pos, missing, kexp[t]);
      end
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL impulse_empty valid=%b expected=0", valid_out);
      end
    end
  endtask

  // Reader drains block 0 while block 1 fills; both finish on the same edge.
  task automatic test_simultaneous();
    int bad = 0;
    make_block(0);
    make_block(1);
    feed_block(0);
    for (int i = 0; i < 192; i++) begin
      @(negedge clk_100);
      valid_in = 1'b1;
      data_in  = txb[1][i];
      ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== orig[0][i] || sob_out !== (i == 0) ||
          ready_out !== 1'b1) begin
        failures++;
        bad++;
        $display("FAIL overlap_blk0 k=%0d valid=%b data=%b sob=%b ready=%b expected 1 %b %b 1",
                 i, valid_out, data_out, sob_out, ready_out, orig[0][i], (i == 0));
      end
    end
    @(negedge clk_100);
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || sob_out !== 1'b1 || data_out !== orig[1][0] || ready_out !== 1'b1)
    begin
      failures++;
      $display("FAIL simultaneous_switch valid=%b sob=%b data=%b ready=%b expected 1 1 %b 1",
               valid_out, sob_out, data_out, ready_out, orig[1][0]);
    end
    for (int k = 0; k < 192; k++) begin
      ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== orig[1][k] || sob_out !== (k == 0)) begin
        failures++;
        $display("FAIL overlap_blk1 k=%0d valid=%b data=%b sob=%b expected 1 %b %b",
                 k, valid_out, data_out, sob_out, orig[1][k], (k == 0));
      end
      @(negedge clk_100);
    end
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous_empty valid=%b expected=0", valid_out);
    end
  endtask

  task automatic test_full_backpressure();
    int acc = 0;
    int guard = 0;
    int leaks = 0;
    make_block(0);
    make_block(1);
    @(negedge clk_100);
    ready_in = 1'b0;
    while (guard < 600) begin
      valid_in = 1'b1;
      data_in  = (acc < 192) ? txb[0][acc] : (acc < 384) ? txb[1][acc - 192] : 1'($urandom);
      if (!ready_out) break;
      acc++;
      guard++;
      @(negedge clk_100);
    end
    checks++;
    if (acc != 384) begin
      failures++;
      $display("FAIL full_accept_count got=%0d expected=384", acc);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_100);
      if (ready_out !== 1'b0) leaks++;
    end
    checks++;
    if (leaks != 0) begin
      failures++;
      $display("FAIL full_ready_held high_cycles=%0d expected=0", leaks);
    end
    valid_in = 1'b0;
    for (int n = 0; n < 384; n++) begin
      int blk = n / 192;
      int k = n % 192;
      ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== orig[blk][k] || sob_out !== (k == 0)) begin
        failures++;
        $display("FAIL full_drain blk=%0d k=%0d valid=%b data=%b sob=%b expected 1 %b %b",
                 blk, k, valid_out, data_out, sob_out, orig[blk][k], (k == 0));
      end
      if (n == 191) begin
        checks++;
        if (ready_out !== 1'b0) begin
          failures++;
          $display("FAIL full_ready_at_last got=%b expected=0", ready_out);
        end
      end
      if (n == 192) begin
        checks++;
        if (ready_out !== 1'b1) begin
          failures++;
          $display("FAIL full_ready_after_last got=%b expected=1", ready_out);
        end
      end
      @(negedge clk_100);
    end
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL full_empty valid=%b expected=0", valid_out);
    end
  endtask

  // Random stream through the TX model; model tracks only how many whole blocks are stored.
  task automatic test_stream(input int nblk, input int rdy_pct, input string tag);
    bit in_q [$];
    bit exp_q [$];
    bit sob_q [$];
    bit o [192];
    bit t [192];
    int full_cnt = 0;
    int wr_pos = 0;
    int rd_pos = 0;
    int gaps = 0;
    int cycles = 0;
    int budget = nblk * 192 * 4 + 1000;
    bit started = 1'b0;
    bit prev_stall = 1'b0;
    logic prev_data = 1'b0;
    logic prev_sob = 1'b0;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 192; k++) begin
        o[k] = 1'($urandom);
        exp_q.push_back(o[k]);
        sob_q.push_back(k == 0);
      end
      for (int k = 0; k < 192; k++) t[12 * (k % 16) + k / 16] = o[k];
      for (int j = 0; j < 192; j++) in_q.push_back(t[j]);
    end
    while (exp_q.size() > 0 && cycles < budget) begin
      bit wr_done = 1'b0;
      bit rd_done = 1'b0;
      @(negedge clk_100);
      cycles++;
      valid_in = (in_q.size() > 0);
      data_in  = (in_q.size() > 0) ? in_q[0] : 1'b0;
      ready_in = ($urandom_range(99) < rdy_pct);
      checks++;
      if (ready_out !== (full_cnt < 2) || valid_out !== (full_cnt > 0)) begin
        failures++;
        $display("FAIL %s flags ready=%b valid=%b expected ready=%b valid=%b",
                 tag, ready_out, valid_out, (full_cnt < 2), (full_cnt > 0));
      end
      if (valid_out) begin
        started = 1'b1;
        checks++;
        if (data_out !== exp_q[0] || sob_out !== sob_q[0]) begin
          failures++;
          $display("FAIL %s bit=%0d data=%b sob=%b expected data=%b sob=%b",
                   tag, rd_pos, data_out, sob_out, exp_q[0], sob_q[0]);
        end
      end else if (started) begin
        gaps++;
      end
      if (prev_stall) begin
        checks++;
        if (data_out !== prev_data || sob_out !== prev_sob) begin
          failures++;
          $display("FAIL %s stall_hold data=%b sob=%b expected data=%b sob=%b",
                   tag, data_out, sob_out, prev_data, prev_sob);
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_sob   = sob_out;
      if (valid_in && ready_out) begin
        void'(in_q.pop_front());
        wr_pos++;
        if (wr_pos == 192) begin
          wr_pos = 0;
          wr_done = 1'b1;
        end
      end
      if (valid_out && ready_in) begin
        void'(exp_q.pop_front());
        void'(sob_q.pop_front());
        rd_pos = (rd_pos + 1) % 192;
        if (rd_pos == 0) rd_done = 1'b1;
      end
      full_cnt = full_cnt + int'(wr_done) - int'(rd_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout remaining_bits=%0d expected=0", tag, exp_q.size());
    end
    if (rdy_pct >= 100) begin
      checks++;
      if (gaps != 0) begin
        failures++;
        $display("FAIL %s output_gaps got=%0d expected=0", tag, gaps);
      end
    end
    @(negedge clk_100);
    valid_in = 1'b0;
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL %s final valid=%b ready=%b expected valid=0 ready=1", tag, valid_out, ready_out);
    end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    make_block(0);
    make_block(1);
    make_block(2);
    feed_block(0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100);
      valid_in = 1'b1;
      data_in  = txb[1][i];
      ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== orig[0][i]) begin
        failures++;
        $display("FAIL midreset_pre k=%0d valid=%b data=%b expected 1 %b",
                 i, valid_out, data_out, orig[0][i]);
      end
    end
    @(negedge clk_100);
    valid_in = 1'b0;
    ready_in = 1'b0;
    reset_N  = 1'b0;
    #1;
    checks++;
    if ({valid_out, ready_out, data_out, sob_out} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_outputs got=%b expected=0000",
               {valid_out, ready_out, data_out, sob_out});
    end
    @(negedge clk_100);
    checks++;
    if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_held ready=%b valid=%b expected 0 0", ready_out, valid_out);
    end
    reset_N = 1'b1;
    for (int j = 0; j < 192; j++) begin
      int guard = 0;
      @(negedge clk_100);
      valid_in = 1'b1;
      data_in  = txb[2][j];
      ready_in = 1'b1;
      if (valid_out) early++;
      while (!ready_out && guard < 10) begin
        @(negedge clk_100);
        if (valid_out) early++;
        guard++;
      end
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL midreset_remnant valid_cycles=%0d expected=0", early);
    end
    @(negedge clk_100);
    valid_in = 1'b0;
    for (int k = 0; k < 192; k++) begin
      ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== orig[2][k] || sob_out !== (k == 0)) begin
        failures++;
        $display("FAIL midreset_post k=%0d valid=%b data=%b sob=%b expected 1 %b %b",
                 k, valid_out, data_out, sob_out, orig[2][k], (k == 0));
      end
      @(negedge clk_100);
    end
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_empty valid=%b expected=0", valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_simultaneous();
    test_full_backpressure();
    test_stream(150, 100, "stream_full_rate");
    test_stream(30, 50, "stream_backpressure");
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
